fifo_wptr_gen: RTL and testbench

// Write-side pointer generator for the router's async FIFO. Keeps the binary/Gray write pointer,

---
 rtl/fifo_wptr_gen.sv | 82 ++++++++
 tb/tb_fifo_wptr_gen.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fifo_wptr_gen.sv
// Write-side pointer generator for an async FIFO: binary/Gray write pointer, full, fill level, overflow.
// Optional almost-full flag is built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_gen #(
  parameter int unsigned PTR_SZ    = 2,
  parameter int unsigned AF_THRESH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rq2_raddr,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic [PTR_SZ:0]   wlevel,
  output logic              woverflow,
  output logic              walmost_full
);

  localparam int unsigned PW = PTR_SZ + 1;

  // Reject parameter sets the pointer arithmetic cannot represent.
  if (PTR_SZ < 2 || AF_THRESH < 1 || AF_THRESH > (1 << PTR_SZ)) begin : g_param_check
    $error("fifo_wptr_gen: illegal PTR_SZ/AF_THRESH");
  end

  logic [PTR_SZ:0] wbin;
  logic [PTR_SZ:0] wbin_next;
  logic [PTR_SZ:0] wgray_next;
  logic [PTR_SZ:0] rbin;
  logic [PTR_SZ:0] full_gray;
  logic [PTR_SZ:0] level_next;
  logic            wen;

  // Next-pointer, read-pointer decode, full compare value and fill level.
  always_comb begin
    wen        = winc & ~wfull;
    wbin_next  = wbin + PW'(wen);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    full_gray  = {~rq2_raddr[PTR_SZ:PTR_SZ-1], rq2_raddr[PTR_SZ-2:0]};
    rbin       = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin[i] = ^(rq2_raddr >> i);
    end
    level_next = wbin_next - rbin;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wbin       <= '0;
      waddr_gray <= '0;
      wfull      <= 1'b0;
      wlevel     <= '0;
      woverflow  <= 1'b0;
    end else begin
      wbin       <= wbin_next;
      waddr_gray <= wgray_next;
      wfull      <= (wgray_next == full_gray);
      wlevel     <= level_next;
      // Sticky until reset; a write attempt against a full FIFO is dropped.
      if (winc & wfull) begin
        woverflow <= 1'b1;
      end
    end
  end

  assign waddr = wbin[PTR_SZ-1:0];

`ifdef FIFO_ALMOST_FULL_EN
  localparam logic [PTR_SZ:0] AF_LVL = PW'(AF_THRESH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      walmost_full <= 1'b0;
    end else begin
      walmost_full <= (level_next >= AF_LVL);
    end
  end
`else
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_gen.sv
// Directed self-checking bench for fifo_wptr_gen at PTR_SZ=2, AF_THRESH=3.
module tb_fifo_wptr_gen;

`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [2:0] rq2_raddr;
  logic [1:0] waddr;
  logic [2:0] waddr_gray;
  logic       wfull;
  logic [2:0] wlevel;
  logic       woverflow;
  logic       walmost_full;

  int checks = 0;
  int errors = 0;

  // Wrap phase: read pointer lags the write pointer by one entry.
  logic [2:0] wrap_rq   [8] = '{3'b111, 3'b101, 3'b100, 3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
  logic [2:0] wrap_gray [8] = '{3'b101, 3'b100, 3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
  logic [1:0] wrap_addr [8] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  fifo_wptr_gen #(.PTR_SZ(2), .AF_THRESH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rq2_raddr    (rq2_raddr),
    .waddr        (waddr),
    .waddr_gray   (waddr_gray),
    .wfull        (wfull),
    .wlevel       (wlevel),
    .woverflow    (woverflow),
    .walmost_full (walmost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_addr, input logic [2:0] e_gray,
                           input logic e_full, input logic [2:0] e_lvl, input logic e_ovf,
                           input logic e_af);
    chk({tag, ".waddr"},        8'(waddr),        8'(e_addr));
    chk({tag, ".waddr_gray"},   8'(waddr_gray),   8'(e_gray));
    chk({tag, ".wfull"},        8'(wfull),        8'(e_full));
    chk({tag, ".wlevel"},       8'(wlevel),       8'(e_lvl));
    chk({tag, ".woverflow"},    8'(woverflow),    8'(e_ovf));
    chk({tag, ".walmost_full"}, 8'(walmost_full), 8'(e_af));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two edges with live-looking inputs.
    rst = 1'b0; winc = 1'b1; rq2_raddr = 3'b110;
    tick(); tick();
    check_all("reset", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1; winc = 1'b0; rq2_raddr = 3'b000;
    tick();
    check_all("post_reset_idle", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0);

    // Fill from empty.
    winc = 1'b1;
    tick(); check_all("fill1", 2'd1, 3'b001, 1'b0, 3'd1, 1'b0, 1'b0);
    tick(); check_all("fill2", 2'd2, 3'b011, 1'b0, 3'd2, 1'b0, 1'b0);
    tick(); check_all("fill3", 2'd3, 3'b010, 1'b0, 3'd3, 1'b0, AF_EN);
    tick(); check_all("fill4", 2'd0, 3'b110, 1'b1, 3'd4, 1'b0, AF_EN);

    // Writes against a full FIFO: pointer holds, overflow sticks.
    tick(); check_all("ovf1", 2'd0, 3'b110, 1'b1, 3'd4, 1'b1, AF_EN);
    tick(); check_all("ovf2", 2'd0, 3'b110, 1'b1, 3'd4, 1'b1, AF_EN);

    // Read side releases one entry, then one write refills.
    winc = 1'b0; rq2_raddr = 3'b001;
    tick(); check_all("release", 2'd0, 3'b110, 1'b0, 3'd3, 1'b1, AF_EN);
    winc = 1'b1;
    tick(); check_all("refill", 2'd1, 3'b111, 1'b1, 3'd4, 1'b1, AF_EN);

    // Drain completely (read pointer catches up to wbin=5).
    winc = 1'b0; rq2_raddr = 3'b111;
    tick(); check_all("drain", 2'd1, 3'b111, 1'b0, 3'd0, 1'b1, 1'b0);

    // Wrap through 111->000 with the read side one behind.
    winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rq2_raddr = wrap_rq[i];
      tick();
      check_all($sformatf("wrap%0d", i), wrap_addr[i], wrap_gray[i], 1'b0, 3'd1, 1'b1, 1'b0);
    end

    // Almost-full: empty, three writes, then a release down to level 2.
    winc = 1'b0; rq2_raddr = 3'b111;
    tick(); check_all("af_empty", 2'd1, 3'b111, 1'b0, 3'd0, 1'b1, 1'b0);
    winc = 1'b1;
    tick(); check_all("af_w1", 2'd2, 3'b101, 1'b0, 3'd1, 1'b1, 1'b0);
    tick(); check_all("af_w2", 2'd3, 3'b100, 1'b0, 3'd2, 1'b1, 1'b0);
    tick(); check_all("af_w3", 2'd0, 3'b000, 1'b0, 3'd3, 1'b1, AF_EN);
    winc = 1'b0; rq2_raddr = 3'b101;
    tick(); check_all("af_drop", 2'd0, 3'b000, 1'b0, 3'd2, 1'b1, 1'b0);

    // Reset mid-operation with a pending write clears everything, including overflow.
    rst = 1'b0; winc = 1'b1;
    tick(); check_all("mid_reset", 2'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
